// File: rtl/iter_calc.sv
// ---------------------------------------------------------------------------
// iter_calc -- iterative arithmetic unit.
//
// Computes either the triangular number T(x) = 1+2+...+x (mode=0) or the
// square x*x (mode=1) by repeated addition, one addition per clock. Results
// that do not fit in OW bits saturate to 2^OW-1 and raise ovf.
//
// Parameters:
//   W   operand width
//   OW  result width (any OW >= 1)
//
// Ports:
//   clk    system clock, rising edge
//   rst    asynchronous reset, active low
//   xval   request strobe, sampled only in IDLE
//   mode   0 = triangular, 1 = square; sampled with xval
//   abort  (only with ITER_CALC_ABORT_EN) abandon the running operation
//   x      operand, sampled with xval
//   busy   high while RUN or DONE
//   y      result, held until the next completed operation
//   yval   one-cycle result-valid pulse
//   ovf    saturation flag, loaded together with y
//
// Optional feature macro: ITER_CALC_ABORT_EN adds the abort input.
// ---------------------------------------------------------------------------
module iter_calc #(
    parameter int W  = 4,
    parameter int OW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          xval,
    input  logic          mode,
`ifdef ITER_CALC_ABORT_EN
    input  logic          abort,
`endif
    input  logic [W-1:0]  x,
    output logic          busy,
    output logic [OW-1:0] y,
    output logic          yval,
    output logic          ovf
);

    // Sum width large enough that acc + addend never wraps, whatever the
    // relation between W and OW.
    localparam int SW = ((OW > W) ? OW : W) + 1;
    localparam logic [OW:0] ACC_MAX = {1'b0, {OW{1'b1}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_reg;
    logic [W-1:0]  xr_reg;
    logic          mr_reg;
    logic [OW:0]   acc_reg;
    logic [W-1:0]  cnt_reg;
    logic          sat_reg;
    logic [OW-1:0] y_reg;
    logic          ovf_reg;
    logic          yval_reg;
    logic          busy_reg;

    logic [W-1:0]  addend;
    logic [SW-1:0] sum_wide;
    logic          over;
    logic [OW:0]   acc_next;
    logic          sat_next;
    logic          abort_hit;

`ifdef ITER_CALC_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    // One saturating addition step of the RUN state.
    always_comb begin
        addend   = mr_reg ? xr_reg : cnt_reg;
        sum_wide = SW'(acc_reg) + SW'(addend);
        over     = (sum_wide > SW'(ACC_MAX));
        acc_next = over ? ACC_MAX : sum_wide[OW:0];
        sat_next = sat_reg | over;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            xr_reg    <= '0;
            mr_reg    <= 1'b0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            sat_reg   <= 1'b0;
            y_reg     <= '0;
            ovf_reg   <= 1'b0;
            yval_reg  <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    yval_reg <= 1'b0;
                    if (xval) begin
                        xr_reg   <= x;
                        mr_reg   <= mode;
                        acc_reg  <= '0;
                        cnt_reg  <= x;
                        sat_reg  <= 1'b0;
                        busy_reg <= 1'b1;
                        if (x == '0) begin
                            // Nothing to add: result is known immediately.
                            y_reg     <= '0;
                            ovf_reg   <= 1'b0;
                            yval_reg  <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            state_reg <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (abort_hit) begin
                        // Pending result load is dropped; y/ovf untouched.
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        yval_reg  <= 1'b0;
                    end else begin
                        acc_reg <= acc_next;
                        cnt_reg <= cnt_reg - W'(1);
                        sat_reg <= sat_next;
                        if (cnt_reg == W'(1)) begin
                            y_reg     <= acc_next[OW-1:0];
                            ovf_reg   <= sat_next;
                            yval_reg  <= 1'b1;
                            state_reg <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Leaves after one cycle, aborted or not.
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    yval_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    yval_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign y    = y_reg;
    assign yval = yval_reg;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_iter_calc.sv
// ---------------------------------------------------------------------------
// tb_iter_calc -- self-checking bench for iter_calc.
// Two instances: u8 (W=4, OW=8) and u6 (W=4, OW=6). Expected results are
// pushed to a per-instance queue when a request is driven and compared when
// the instance raises yval.
// ---------------------------------------------------------------------------
module tb_iter_calc;

    logic       clk;
    logic       rst;

    logic       xval8, mode8, abort8;
    logic [3:0] x8;
    logic       busy8, yval8, ovf8;
    logic [7:0] y8;

    logic       xval6, mode6, abort6;
    logic [3:0] x6;
    logic       busy6, yval6, ovf6;
    logic [5:0] y6;

    int errors = 0;
    int checks = 0;
    int yv8 = 0;
    int yv6 = 0;
    int q8[$];
    int q6[$];

    iter_calc #(.W(4), .OW(8)) u8 (
        .clk(clk), .rst(rst), .xval(xval8), .mode(mode8),
`ifdef ITER_CALC_ABORT_EN
        .abort(abort8),
`endif
        .x(x8), .busy(busy8), .y(y8), .yval(yval8), .ovf(ovf8)
    );

    iter_calc #(.W(4), .OW(6)) u6 (
        .clk(clk), .rst(rst), .xval(xval6), .mode(mode6),
`ifdef ITER_CALC_ABORT_EN
        .abort(abort6),
`endif
        .x(x6), .busy(busy6), .y(y6), .yval(yval6), .ovf(ovf6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: saturating repeated addition, result in [15:0], ovf in bit 16.
    function automatic int model(input bit m, input int xv, input int ow);
        int acc = 0;
        int mx = (1 << ow) - 1;
        int ov = 0;
        for (int i = xv; i >= 1; i--) begin
            acc += m ? xv : i;
            if (acc > mx) begin
                acc = mx;
                ov = 1;
            end
        end
        return acc | (ov << 16);
    endfunction

    // Scoreboard monitors
    always @(negedge clk) begin
        if (rst && yval8) begin
            int e;
            yv8++;
            if (q8.size() == 0) begin
                check_eq("u8_unexpected_yval", 1, 0);
            end else begin
                e = q8.pop_front();
                check_eq("u8_y", 32'(y8), e & 16'hFFFF);
                check_eq("u8_ovf", 32'(ovf8), (e >> 16) & 1);
                $display("u8 result y=%0d ovf=%0d", y8, ovf8);
            end
        end
    end

    always @(negedge clk) begin
        if (rst && yval6) begin
            int e;
            yv6++;
            if (q6.size() == 0) begin
                check_eq("u6_unexpected_yval", 1, 0);
            end else begin
                e = q6.pop_front();
                check_eq("u6_y", 32'(y6), e & 16'hFFFF);
                check_eq("u6_ovf", 32'(ovf6), (e >> 16) & 1);
                $display("u6 result y=%0d ovf=%0d", y6, ovf6);
            end
        end
    end

    // Issue one request to u8 (sel=0) or u6 (sel=1), then track latency,
    // busy length and output hold until yval.
    task automatic request(input int sel, input bit m, input int xv);
        int  k;
        int  bcnt;
        bit  seen;
        int  prev_y;
        logic b, v;
        logic [31:0] yy;
        @(negedge clk);
        prev_y = sel ? int'(y6) : int'(y8);
        if (sel == 0) begin
            q8.push_back(model(m, xv, 8));
            xval8 = 1'b1; mode8 = m; x8 = 4'(xv);
        end else begin
            q6.push_back(model(m, xv, 6));
            xval6 = 1'b1; mode6 = m; x6 = 4'(xv);
        end
        $display("req sel=%0d mode=%0d x=%0d", sel, m, xv);
        @(negedge clk);
        // Operand/mode changes after the strobe must have no effect.
        xval8 = 1'b0; xval6 = 1'b0;
        x8 = 4'($urandom); mode8 = 1'($urandom);
        x6 = 4'($urandom); mode6 = 1'($urandom);
        k = 1; bcnt = 0; seen = 0;
        while (!seen && k <= 40) begin
            b  = sel ? busy6 : busy8;
            v  = sel ? yval6 : yval8;
            yy = sel ? 32'(y6) : 32'(y8);
            if (b) bcnt++;
            if (v) begin
                seen = 1;
                check_eq("latency", k, xv + 1);
            end else begin
                check_eq("y_hold", yy, prev_y);
                @(negedge clk);
                k++;
            end
        end
        if (!seen) check_eq("yval_timeout", 0, 1);
        check_eq("busy_cycles", bcnt, xv + 1);
        @(negedge clk);
        check_eq("busy_after", sel ? 32'(busy6) : 32'(busy8), 0);
        check_eq("yval_after", sel ? 32'(yval6) : 32'(yval8), 0);
    endtask

    initial begin
        int base;
        int prev;
        rst = 1'b1;
        xval8 = 0; mode8 = 0; abort8 = 0; x8 = 0;
        xval6 = 0; mode6 = 0; abort6 = 0; x6 = 0;

        // 1. Reset with random inputs
        #2 rst = 1'b0;
        #1;
        check_eq("rst_assert_y", 32'(y8), 0);
        check_eq("rst_assert_busy", 32'(busy8), 0);
        check_eq("rst_assert_yval", 32'(yval8), 0);
        check_eq("rst_assert_ovf", 32'(ovf8), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            xval8 = 1'($urandom); mode8 = 1'($urandom); x8 = 4'($urandom);
            xval6 = 1'($urandom); mode6 = 1'($urandom); x6 = 4'($urandom);
        end
        @(negedge clk);
        xval8 = 0; xval6 = 0;
        rst = 1'b1;
        @(negedge clk);
        check_eq("rel_y", 32'(y8), 0);
        check_eq("rel_busy", 32'(busy8), 0);
        check_eq("rel_yval", 32'(yval8), 0);
        check_eq("rel_ovf", 32'(ovf8), 0);
        check_eq("rel_u6_y", 32'(y6), 0);

        // 2. Triangular
        request(0, 0, 2);
        request(0, 0, 3);
        // 3. Square, boundaries
        request(0, 1, 15);
        request(0, 1, 1);
        request(0, 0, 1);
        request(0, 1, 0);
        request(0, 0, 15);
        // 4. Saturation at OW=6
        request(1, 1, 9);
        request(1, 0, 10);
        request(1, 1, 7);

        // 5a. xval flooding while busy
        @(negedge clk);
        base = yv8;
        q8.push_back(model(0, 4, 8));
        xval8 = 1; mode8 = 0; x8 = 4;
        $display("req flood mode=0 x=4");
        @(negedge clk);
        x8 = 7;
        for (int i = 0; i < 20 && busy8; i++) @(negedge clk);
        xval8 = 0;
        check_eq("flood_idle", 32'(busy8), 0);
        repeat (3) @(negedge clk);
        check_eq("flood_yval_count", yv8 - base, 1);

        // 5b. Reset mid-RUN
        @(negedge clk);
        xval8 = 1; mode8 = 0; x8 = 12;
        $display("req mode=0 x=12 then reset");
        @(negedge clk);
        xval8 = 0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_eq("midrst_y", 32'(y8), 0);
        check_eq("midrst_busy", 32'(busy8), 0);
        check_eq("midrst_yval", 32'(yval8), 0);
        check_eq("midrst_ovf", 32'(ovf8), 0);
        check_eq("midrst_u6_ovf", 32'(ovf6), 0);
        @(negedge clk);
        rst = 1'b1;
        base = yv8;
        repeat (20) @(negedge clk);
        check_eq("midrst_no_yval", yv8 - base, 0);
        check_eq("midrst_busy_after", 32'(busy8), 0);

`ifdef ITER_CALC_ABORT_EN
        // 6. Abort at the third RUN cycle
        request(0, 0, 3);
        @(negedge clk);
        prev = int'(y8);
        base = yv8;
        xval8 = 1; mode8 = 1; x8 = 8;
        $display("req abort mode=1 x=8");
        @(negedge clk);
        xval8 = 0;
        @(negedge clk);
        @(negedge clk);
        abort8 = 1;
        @(negedge clk);
        abort8 = 0;
        check_eq("abort_busy", 32'(busy8), 0);
        check_eq("abort_y", 32'(y8), prev);
        check_eq("abort_yval", 32'(yval8), 0);
        repeat (12) @(negedge clk);
        check_eq("abort_no_yval", yv8 - base, 0);
        request(0, 1, 5);
`else
        prev = 0;
`endif

        check_eq("q8_drained", q8.size(), 0);
        check_eq("q6_drained", q6.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
